// File: rtl/comet_pkg.sv
`default_nettype none
// ============================================================================
// comet_pkg: shared widths, loader state encoding and error codes
// Rev 1.0
// ============================================================================
package comet_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } load_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/comet_prog_loader_if.sv
`default_nettype none
// ============================================================================
// comet_prog_loader_if: word stream handshake plus RAM write/read port
// Rev 1.0
// ============================================================================
interface comet_prog_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  s_valid, s_data, rdata,
    output s_ready, we, waddr, wdata, re, raddr
  );

  modport slave (
    output s_valid, s_data, rdata,
    input  s_ready, we, waddr, wdata, re, raddr
  );
endinterface
`default_nettype wire

// File: rtl/comet_csum16.sv
`default_nettype none
// ============================================================================
// comet_csum16: wrapping accumulator with synchronous clear and enable
// Rev 1.0
// ============================================================================
module comet_csum16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/comet_prog_loader.sv
`default_nettype none
// ============================================================================
// comet_prog_loader: streams a program image into RAM, reads it back, and
// releases the CPU only when the write and read checksums agree.  Rev 1.0
// ============================================================================
module comet_prog_loader #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   length,
  comet_prog_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                cpu_run
);
  import comet_pkg::*;

  load_state_t r_state, w_next_state;

  logic [ADDR_W-1:0] r_len, r_wptr, r_wcnt, r_vcnt;
  logic [DATA_W-1:0] w_wsum, w_rsum, w_rsum_final;
  logic [ADDR_W:0]   w_end_addr;

  logic w_idle_like, w_start_ok, w_len_zero, w_range_bad;
  logic w_accept, w_last_wr, w_v_first, w_v_last, w_csum_ok;

  logic              w_we_d, w_re_d, w_busy_d, w_done_d, w_error_d;
  logic [ADDR_W-1:0] w_waddr_d, w_raddr_d;
  logic [DATA_W-1:0] w_wdata_d;
  logic [1:0]        w_err_d;

  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_start_ok   = start && w_idle_like;
  assign w_len_zero   = (length == '0);
  assign w_end_addr   = {1'b0, BASE_ADDR} + {1'b0, length};
  assign w_range_bad  = w_end_addr > (ADDR_W+1)'(MEM_DEPTH);

  assign bus.s_ready  = (r_state == ST_LOAD);
  assign w_accept     = bus.s_valid && bus.s_ready;
  assign w_last_wr    = w_accept && (r_wcnt == r_len - ADDR_W'(1));

  // Cycle 0 of VERIFY carries the final write; reads start one cycle later.
  assign w_v_first    = (r_state == ST_VERIFY) && (r_vcnt == '0);
  assign w_v_last     = (r_state == ST_VERIFY) && (r_vcnt == r_len);
  assign w_rsum_final = w_rsum + bus.rdata;
  assign w_csum_ok    = (w_wsum == w_rsum_final);

  comet_csum16 #(.WIDTH(DATA_W)) u_wsum (
    .clk (mclk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_accept),
    .din (bus.s_data),
    .sum (w_wsum)
  );

  comet_csum16 #(.WIDTH(DATA_W)) u_rsum (
    .clk (mclk),
    .rst (rst),
    .clr (w_start_ok),
    .en  ((r_state == ST_VERIFY) && bus.re),
    .din (bus.rdata),
    .sum (w_rsum)
  );

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.re    <= 1'b0;
      bus.raddr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      cpu_run   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      bus.we    <= w_we_d;
      bus.waddr <= w_waddr_d;
      bus.wdata <= w_wdata_d;
      bus.re    <= w_re_d;
      bus.raddr <= w_raddr_d;
      busy      <= w_busy_d;
      done      <= w_done_d;
      error     <= w_error_d;
      err_code  <= w_err_d;
      cpu_run   <= w_done_d;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          if (w_len_zero)       w_next_state = ST_DONE;
          else if (w_range_bad) w_next_state = ST_ERROR;
          else                  w_next_state = ST_LOAD;
        end
      end
      ST_LOAD:   if (w_last_wr) w_next_state = ST_VERIFY;
      ST_VERIFY: if (w_v_last)  w_next_state = w_csum_ok ? ST_DONE : ST_ERROR;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we_d    = w_accept;
    w_waddr_d = w_accept ? r_wptr : bus.waddr;
    w_wdata_d = w_accept ? bus.s_data : bus.wdata;
    w_re_d    = 1'b0;
    w_raddr_d = bus.raddr;
    if (w_v_first) begin
      w_re_d    = 1'b1;
      w_raddr_d = BASE_ADDR;
    end else if ((r_state == ST_VERIFY) && !w_v_last) begin
      w_re_d    = 1'b1;
      w_raddr_d = bus.raddr + ADDR_W'(1);
    end
    w_busy_d  = (w_next_state == ST_LOAD) || (w_next_state == ST_VERIFY);
    w_done_d  = (w_next_state == ST_DONE);
    w_error_d = (w_next_state == ST_ERROR);
    w_err_d   = err_code;
    if (w_start_ok) begin
      w_err_d = (!w_len_zero && w_range_bad) ? ERR_RANGE : ERR_NONE;
    end else if (w_v_last && !w_csum_ok) begin
      w_err_d = ERR_CSUM;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_len  <= '0;
      r_wptr <= '0;
      r_wcnt <= '0;
      r_vcnt <= '0;
    end else if (w_start_ok) begin
      r_len  <= length;
      r_wptr <= BASE_ADDR;
      r_wcnt <= '0;
      r_vcnt <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + ADDR_W'(1);
        r_wcnt <= r_wcnt + ADDR_W'(1);
      end
      if (r_state == ST_VERIFY) begin
        r_vcnt <= r_vcnt + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comet_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_comet_prog_loader: directed vector table plus reset / start-ignore cases
// Rev 1.0
// ============================================================================
module tb_comet_prog_loader;
  import comet_pkg::*;

  logic        mclk, rst, start;
  logic [15:0] length;
  logic        busy, done, error, cpu_run;
  logic [1:0]  err_code;

  comet_prog_loader_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  comet_prog_loader #(
    .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(128), .BASE_ADDR(16'h0000)
  ) dut (
    .mclk(mclk), .rst(rst), .start(start), .length(length), .bus(bus),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .cpu_run(cpu_run)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  logic [15:0] ram [0:127];
  logic        corrupt_en;
  always @(negedge mclk) if (bus.we) ram[bus.waddr[6:0]] <= bus.wdata;
  // Read-path corruption stands in for a backdoor overwrite of RAM[1].
  assign bus.rdata = (corrupt_en && bus.raddr == 16'd1) ? 16'hFFFF : ram[bus.raddr[6:0]];

  int          we_n = 0, re_n = 0, both_n = 0;
  logic [15:0] wlog [0:511];
  logic [15:0] rlog [0:511];
  always @(negedge mclk) begin
    if (bus.we) begin wlog[we_n % 512] = bus.waddr; we_n++; end
    if (bus.re) begin rlog[re_n % 512] = bus.raddr; re_n++; end
    if (bus.we && bus.re) both_n++;
  end

  int checks = 0, errors = 0;
  logic [15:0] img [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic feed(input logic [15:0] len, input logic [15:0] vpat,
                      output int cyc, output bit timed_out);
    int idx;
    bit hs;
    idx = 0; cyc = 0; timed_out = 1'b1;
    while (cyc < 400) begin
      bus.s_valid = (idx < int'(len)) && vpat[cyc % 16];
      bus.s_data  = img[idx % 4];
      @(negedge mclk);
      if (done || error) begin timed_out = 1'b0; break; end
      hs = bus.s_valid && bus.s_ready;
      @(posedge mclk); #1;
      if (hs) idx++;
      cyc++;
    end
    bus.s_valid = 1'b0;
    @(posedge mclk); #1;
  endtask

  task automatic run_load(input logic [15:0] len, input logic [15:0] vpat, input bit corrupt,
                          output int cyc, output bit timed_out);
    corrupt_en = corrupt;
    @(posedge mclk); #1;
    start = 1'b1; length = len;
    @(posedge mclk); #1;
    start = 1'b0;
    feed(len, vpat, cyc, timed_out);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [15:0] vpat;
    bit          corrupt;
    bit          exp_done;
    bit          exp_error;
    logic [1:0]  exp_code;
    int          exp_we;
    int          exp_re;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  we0, re0, cyc, mism;
    bit  tmo;
    img[0] = 16'h1210; img[1] = 16'h0003; img[2] = 16'h1200; img[3] = 16'h8000;
    //         len     vpat      corr done err code   we   re  cyc
    vecs[0] = '{16'd4,   16'hFFFF, 1'b0, 1'b1, 1'b0, ERR_NONE,  4,   4,   9};
    vecs[1] = '{16'd4,   16'h9999, 1'b0, 1'b1, 1'b0, ERR_NONE,  4,   4,  13};
    vecs[2] = '{16'd129, 16'hFFFF, 1'b0, 1'b0, 1'b1, ERR_RANGE, 0,   0,   0};
    vecs[3] = '{16'd4,   16'hFFFF, 1'b1, 1'b0, 1'b1, ERR_CSUM,  4,   4,   9};
    vecs[4] = '{16'd0,   16'hFFFF, 1'b0, 1'b1, 1'b0, ERR_NONE,  0,   0,   0};
    vecs[5] = '{16'd128, 16'hFFFF, 1'b0, 1'b1, 1'b0, ERR_NONE,  128, 128, 257};
    vecs[6] = '{16'd3,   16'h5555, 1'b0, 1'b1, 1'b0, ERR_NONE,  3,   3,   9};

    rst = 1'b1; start = 1'b0; length = '0; corrupt_en = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge mclk);
    #1;
    check("reset_flags", {busy, done, error, err_code, cpu_run}, 0);
    check("reset_bus", {bus.we, bus.re, bus.s_ready, bus.waddr, bus.raddr, bus.wdata}, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      we0 = we_n; re0 = re_n;
      run_load(vecs[i].len, vecs[i].vpat, vecs[i].corrupt, cyc, tmo);
      check($sformatf("v%0d_timeout", i), tmo, 1'b0);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("v%0d_cpu_run", i), cpu_run, vecs[i].exp_done);
      check($sformatf("v%0d_error", i), error, vecs[i].exp_error);
      check($sformatf("v%0d_err_code", i), err_code, vecs[i].exp_code);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      check($sformatf("v%0d_we_count", i), we_n - we0, vecs[i].exp_we);
      check($sformatf("v%0d_re_count", i), re_n - re0, vecs[i].exp_re);
      mism = 0;
      for (int k = 0; k < vecs[i].exp_we; k++) begin
        if (wlog[(we0 + k) % 512] !== 16'(k)) mism++;
        if (ram[k] !== img[k % 4]) mism++;
      end
      check($sformatf("v%0d_waddr_ram", i), mism, 0);
      mism = 0;
      for (int k = 0; k < vecs[i].exp_re; k++) begin
        if (rlog[(re0 + k) % 512] !== 16'(k)) mism++;
      end
      check($sformatf("v%0d_raddr_seq", i), mism, 0);
      check($sformatf("v%0d_we_re_overlap", i), both_n, 0);
    end
    check("ram2_value", ram[2], 16'h1200);

    // Reset after two of four words have been accepted.
    corrupt_en = 1'b0;
    we0 = we_n;
    @(posedge mclk); #1; start = 1'b1; length = 16'd4;
    @(posedge mclk); #1; start = 1'b0; bus.s_valid = 1'b1; bus.s_data = img[0];
    @(posedge mclk); #1; bus.s_data = img[1];
    @(posedge mclk); #1; bus.s_data = img[2]; rst = 1'b1;
    @(posedge mclk); #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_we", bus.we, 1'b0);
    check("rst_mid_s_ready", bus.s_ready, 1'b0);
    rst = 1'b0; bus.s_valid = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check("rst_mid_we_pulses", we_n - we0, 2);
    check("rst_mid_ram1", ram[1], 16'h0003);
    run_load(16'd4, 16'hFFFF, 1'b0, cyc, tmo);
    check("rst_reload_timeout", tmo, 1'b0);
    check("rst_reload_done", done, 1'b1);

    // A start pulse while loading must not restart or finish the load.
    @(posedge mclk); #1; start = 1'b1; length = 16'd4; bus.s_valid = 1'b0;
    @(posedge mclk); #1; start = 1'b0;
    @(posedge mclk); #1; start = 1'b1; length = 16'd0;
    @(posedge mclk); #1; start = 1'b0;
    check("ign_start_busy", busy, 1'b1);
    check("ign_start_done", done, 1'b0);
    check("ign_start_s_ready", bus.s_ready, 1'b1);
    we0 = we_n;
    feed(16'd4, 16'hFFFF, cyc, tmo);
    check("ign_start_timeout", tmo, 1'b0);
    check("ign_start_cycles", cyc, 9);
    check("ign_start_final_done", done, 1'b1);
    check("ign_start_err_code", err_code, ERR_NONE);
    check("ign_start_we_count", we_n - we0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comet_prog_loader.md
Name: comet_prog_loader

Overview:
Bus initiator that fills the COMET II program RAM before the CPU runs. It accepts a stream of 16-bit words over a valid/ready handshake and drives the RAM write port. It then reads the image back through the RAM read port and compares checksums. It releases the CPU (cpu_run) only after a clean verify; the CPU's fetch path is gated off while the loader is busy.

Parameters:
DATA_W, 16, RAM word width
ADDR_W, 16, RAM address width (RAM decodes low bits only)
MEM_DEPTH, 128, number of RAM words
BASE_ADDR, 16'h0000, first word address written

Ports:
mclk  in  1  system clock; all loader logic on posedge (RAM writes on negedge)
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load (ignored while busy)
length  in  ADDR_W  word count, sampled on start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  loader can accept s_data
we  out  1  RAM write enable
waddr  out  ADDR_W  RAM write address
wdata  out  DATA_W  RAM write data
re  out  1  RAM read enable
raddr  out  ADDR_W  RAM read address
rdata  in  DATA_W  RAM read data (combinational from raddr)
busy  out  1  in LOAD or VERIFY
done  out  1  image loaded and verified (sticky)
error  out  1  bounds or checksum failure (sticky)
err_code  out  2  0 none, 1 length out of range, 2 checksum mismatch
cpu_run  out  1  CPU release; equals done

Behaviour:
- Reset values: all outputs 0; state IDLE; checksums, pointers and counters 0.
- Reset mid-operation: the next posedge forces the reset values. The loader issues no further we after that edge. RAM contents already written are left as is.
- States: IDLE, LOAD, VERIFY, DONE, ERROR. All outputs are registered except s_ready, which is 1 exactly when state is LOAD.
- IDLE, DONE or ERROR on start:
  - Clear done, error, err_code and both sums.
  - length == 0 -> DONE next cycle; checksums are trivially equal.
  - BASE_ADDR + length > MEM_DEPTH -> ERROR with err_code=1. No RAM access is made.
  - Otherwise latch length, set wptr=BASE_ADDR and go to LOAD.
- LOAD:
  - Each posedge with s_valid & s_ready: we<=1, waddr<=wptr, wdata<=s_data, wsum<=wsum+s_data (mod 2^16), wptr++.
  - Any other cycle: we<=0.
  - The RAM commits at the following negedge, so each accepted word is in RAM within half a cycle.
  - Stalls (s_valid low) are unlimited.
  - After the length-th accepted word, go to VERIFY. The last we pulse is still issued.
- VERIFY:
  - re=1 throughout. raddr steps BASE_ADDR .. BASE_ADDR+length-1, one address per cycle.
  - rdata for raddr is sampled on the next posedge: rsum<=rsum+rdata.
  - The first raddr is presented one cycle after the final we, so the final word has committed before it is read.
  - Takes length+1 cycles. Then re<=0 and wsum is compared with rsum: equal -> DONE, else ERROR with err_code=2.
- DONE: done=1, cpu_run=1, held until rst or an accepted start.
- ERROR: error=1, cpu_run=0, held until rst or start.
- start during LOAD or VERIFY is ignored.
- we and re are never asserted in the same cycle.
- Arithmetic: both sums wrap modulo 2^16. Address pointers never exceed BASE_ADDR+length-1 because of the bounds check.

Decomposition:
- Shared package comet_pkg:
  - DATA_W and ADDR_W
  - loader state enum
  - err_code constants ERR_NONE, ERR_RANGE, ERR_CSUM
- Optional sub-module comet_csum16: 16-bit wrapping accumulator with clear and enable. It is instanced twice, once for wsum and once for rsum.
- The FSM stays in comet_prog_loader.

Test Plan:
- Load 4 words {1210,0003,1200,8000}, s_valid always high. Required: 4 we pulses at waddr 0..3 on consecutive cycles; then re for 4 addresses plus 1 extra cycle; done=1, cpu_run=1, RAM[2]=1200.
- Same image with s_valid toggled 1,0,0,1,… Required: we only on handshake cycles, waddr still contiguous, done=1.
- length=129 with MEM_DEPTH=128. Required: error=1, err_code=1, no we or re pulse ever asserted.
- Force RAM[1]=FFFF after its write (bench backdoor, during VERIFY setup). Required: error=1, err_code=2, cpu_run=0.
- rst asserted after 2 of 4 words. Required: next cycle busy=0, we=0, s_ready=0; a subsequent start with length 4 completes to done=1.
- start pulsed during LOAD is ignored. length=0 -> done=1 one cycle after start, with no RAM access.
